// File: rtl/ddr3_stream_pkg.sv
// Shared constants and state encoding for the DDR3 read-side sample streamer.
package ddr3_stream_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  localparam int unsigned ADDR_STEP_DEF    = 8;
  localparam int unsigned SAMPLES_PER_WORD = 16;

  typedef enum logic [1:0] {
    StIdle,
    StWaitCal,
    StIssue,
    StDrain
  } state_e;

endpackage

// File: rtl/ddr3_rd_fifo.sv
// Read-data FIFO; the streamer's credit scheme guarantees no overflow or underflow.
module ddr3_rd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

  assign pop_data = mem_q[rptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));

endmodule

// File: rtl/ddr3_sample_streamer.sv
// Reads a contiguous region through the MIG app interface and streams it out as
// 16-bit samples, LSB sample first, with optional looping over the region.
module ddr3_sample_streamer
  import ddr3_stream_pkg::*;
#(
  parameter int unsigned ADDR_W     = 29,
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_STEP  = ADDR_STEP_DEF
) (
  input  logic                ui_clk,
  input  logic                ui_clk_sync_rst,
  input  logic                init_calib_complete,
  input  logic                start,
  input  logic                stop,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [15:0]         num_words,
  input  logic                loop_en,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  input  logic                app_rdy,
  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_valid,
  input  logic                sample_ready
);

  localparam int unsigned SPW = DATA_W / SAMPLE_W;
  localparam int unsigned IW  = $clog2(SPW);
  localparam int unsigned OW  = $clog2(FIFO_DEPTH + 2);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, base_q, base_d;
  logic [15:0]         nwords_q, nwords_d, wcnt_q, wcnt_d;
  logic                loop_q, loop_d, busy_q, busy_d, done_q, done_d;
  logic                stop_q, stop_d, err_q, err_d;
  logic [OW-1:0]       out_q, out_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                uv_q, uv_d;

  logic                credit_ok, accept, last_word, rd_ok, xfer, last_idx;
  logic                fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [DATA_W-1:0]   fifo_rdata;
  logic [CW-1:0]       fifo_cnt;

  ddr3_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (ui_clk),
    .rst       (ui_clk_sync_rst),
    .push      (fifo_push),
    .push_data (app_rd_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .count     (fifo_cnt),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Buffered-or-in-flight words, including the unpack register, never exceed
  // FIFO_DEPTH+1; the sum only grows on accept, so a raised app_en stays up.
  assign credit_ok = (32'(out_q) + 32'(fifo_cnt) + 32'(uv_q)) < 32'(FIFO_DEPTH + 1);
  assign app_en    = (state_q == StIssue) && credit_ok;
  assign accept    = app_en && app_rdy;
  assign last_word = (wcnt_q == nwords_q - 16'd1);
  assign rd_ok     = app_rd_data_valid && (out_q != '0);
  assign fifo_push = rd_ok && (!fifo_full || fifo_pop);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    base_d   = base_q;
    nwords_d = nwords_q;
    loop_d   = loop_q;
    wcnt_d   = wcnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    stop_d   = stop_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_words == 16'd0) begin
            done_d = 1'b1;
          end else begin
            base_d   = base_addr;
            addr_d   = base_addr;
            nwords_d = num_words;
            loop_d   = loop_en;
            wcnt_d   = '0;
            busy_d   = 1'b1;
            stop_d   = 1'b0;
            state_d  = init_calib_complete ? StIssue : StWaitCal;
          end
        end
      end
      StWaitCal: begin
        if (stop)                     state_d = StDrain;
        else if (init_calib_complete) state_d = StIssue;
      end
      StIssue: begin
        if (accept) begin
          addr_d = addr_q + ADDR_W'(ADDR_STEP);
          wcnt_d = wcnt_q + 16'd1;
          if (last_word) begin
            if (loop_q) begin
              addr_d = base_q;
              wcnt_d = '0;
            end else begin
              state_d = StDrain;
            end
          end
          if (stop || stop_q) state_d = StDrain;
        end else if (stop || stop_q) begin
          // A presented command must complete before draining.
          if (app_en) stop_d  = 1'b1;
          else        state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_q == '0 && fifo_empty && !uv_q) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          stop_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    err_d = err_q | (app_rd_data_valid && (out_q == '0));
    out_d = out_q;
    if (accept && !rd_ok)      out_d = out_q + OW'(1);
    else if (!accept && rd_ok) out_d = out_q - OW'(1);
  end

  assign xfer     = uv_q && sample_ready;
  assign last_idx = (idx_q == IW'(SPW - 1));
  assign fifo_pop = !fifo_empty && (!uv_q || (xfer && last_idx));

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    uv_d   = uv_q;
    if (fifo_pop) begin
      word_d = fifo_rdata;
      idx_d  = '0;
      uv_d   = 1'b1;
    end else if (xfer) begin
      idx_d = idx_q + IW'(1);
      if (last_idx) uv_d = 1'b0;
    end
  end

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      base_q   <= '0;
      nwords_q <= '0;
      loop_q   <= 1'b0;
      wcnt_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stop_q   <= 1'b0;
      err_q    <= 1'b0;
      out_q    <= '0;
      word_q   <= '0;
      idx_q    <= '0;
      uv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      base_q   <= base_d;
      nwords_q <= nwords_d;
      loop_q   <= loop_d;
      wcnt_q   <= wcnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      stop_q   <= stop_d;
      err_q    <= err_d;
      out_q    <= out_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      uv_q     <= uv_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign app_addr     = addr_q;
  assign app_cmd      = CMD_READ;
  assign sample_valid = uv_q;
  assign sample_data  = word_q[SAMPLE_W * 32'(idx_q) +: SAMPLE_W];

endmodule

// File: tb/tb_ddr3_sample_streamer.sv
// Scoreboard bench: a MIG model queues expected samples per accepted command and
// a separate monitor pops and compares them as the stream is consumed.
module tb_ddr3_sample_streamer;

  localparam int unsigned ADDR_W     = 29;
  localparam int unsigned DATA_W     = 256;
  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned FIFO_DEPTH = 8;

  logic                ui_clk = 1'b0;
  logic                ui_clk_sync_rst;
  logic                init_calib_complete;
  logic                start;
  logic                stop;
  logic [ADDR_W-1:0]   base_addr;
  logic [15:0]         num_words;
  logic                loop_en;
  logic                busy, done, err;
  logic [ADDR_W-1:0]   app_addr;
  logic [2:0]          app_cmd;
  logic                app_en;
  logic                app_rdy;
  logic [DATA_W-1:0]   app_rd_data;
  logic                app_rd_data_valid;
  logic [SAMPLE_W-1:0] sample_data;
  logic                sample_valid;
  logic                sample_ready;

  always #5 ui_clk = ~ui_clk;

  ddr3_sample_streamer #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .SAMPLE_W   (SAMPLE_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_STEP  (8)
  ) dut (
    .ui_clk              (ui_clk),
    .ui_clk_sync_rst     (ui_clk_sync_rst),
    .init_calib_complete (init_calib_complete),
    .start               (start),
    .stop                (stop),
    .base_addr           (base_addr),
    .num_words           (num_words),
    .loop_en             (loop_en),
    .busy                (busy),
    .done                (done),
    .err                 (err),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .sample_data         (sample_data),
    .sample_valid        (sample_valid),
    .sample_ready        (sample_ready)
  );

  int checks = 0;
  int errors = 0;

  // Job description shared with the MIG model (written by main only).
  int          job_id = 0, job_n = 0, stop_after = 0;
  int unsigned job_base = 0;
  logic [15:0] job_salt = '0;
  int          rdy_mode = 0, sr_mode = 0, dmin = 1, dmax = 3, inject_req = 0;
  int          done0 = 0, got0 = 0;

  // MIG model state.
  int          cyc = 0, seen_id = 0, job_acc = 0, tb_out = 0, max_out = 0;
  int          en_cycles = 0, inject_done = 0;
  logic [DATA_W-1:0] pend_data[$];
  int          pend_due[$];

  logic [15:0] exp_q[$];
  int          got_cnt = 0;
  int          done_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // MIG model: drives app_rdy, records accepted reads and returns data in order.
  initial begin
    logic        prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    prev_stall = 1'b0;
    prev_addr  = '0;
    app_rdy = 1'b0;
    app_rd_data_valid = 1'b0;
    app_rd_data = '0;
    stop = 1'b0;
    forever begin
      @(negedge ui_clk);
      cyc++;
      if (ui_clk_sync_rst) begin
        pend_data.delete();
        pend_due.delete();
        app_rdy = 1'b0;
        app_rd_data_valid = 1'b0;
        stop = 1'b0;
        tb_out = 0;
        prev_stall = 1'b0;
        continue;
      end
      if (seen_id != job_id) begin
        seen_id = job_id;
        job_acc = 0;
      end
      if (prev_stall) begin
        check("cmd_hold_en", app_en, 1);
        check("cmd_hold_addr", app_addr, prev_addr);
      end
      case (rdy_mode)
        0:       app_rdy = 1'b1;
        1:       app_rdy = ~app_rdy;
        default: app_rdy = 1'($urandom_range(0, 1));
      endcase
      stop = 1'b0;
      if (app_en) begin
        en_cycles++;
        if (app_rdy) begin
          logic [DATA_W-1:0] w;
          int unsigned exp_addr;
          exp_addr = job_base + 8 * ((job_n == 0) ? 0 : (job_acc % job_n));
          check("app_addr", app_addr, exp_addr);
          check("app_cmd", app_cmd, 3'b001);
          for (int k = 0; k < 16; k++) begin
            w[16*k +: 16] = 16'(16 * job_acc + k) ^ job_salt;
            exp_q.push_back(w[16*k +: 16]);
          end
          pend_data.push_back(w);
          pend_due.push_back(cyc + $urandom_range(dmin, dmax));
          job_acc++;
          tb_out++;
          if (stop_after != 0 && job_acc == stop_after) stop = 1'b1;
        end
      end
      prev_stall = app_en && !app_rdy;
      prev_addr  = app_addr;
      app_rd_data_valid = 1'b0;
      if (inject_req != inject_done) begin
        inject_done++;
        app_rd_data_valid = 1'b1;
        app_rd_data = {8{$urandom()}};
      end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        app_rd_data_valid = 1'b1;
        app_rd_data = pend_data.pop_front();
        void'(pend_due.pop_front());
        tb_out--;
      end
      if (tb_out > max_out) max_out = tb_out;
    end
  end

  // Sample monitor / scoreboard checker.
  initial begin
    logic        hold;
    logic [15:0] hold_data;
    hold = 1'b0;
    hold_data = '0;
    sample_ready = 1'b0;
    forever begin
      @(negedge ui_clk);
      if (ui_clk_sync_rst) begin
        exp_q.delete();
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        check("sample_hold_valid", sample_valid, 1);
        check("sample_hold_data", sample_data, hold_data);
      end
      case (sr_mode)
        0:       sample_ready = 1'b1;
        1:       sample_ready = 1'b0;
        default: sample_ready = 1'($urandom_range(0, 1));
      endcase
      if (sample_valid && sample_ready) begin
        check("sample_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("sample_data", sample_data, exp_q.pop_front());
        got_cnt++;
      end
      hold = sample_valid && !sample_ready;
      hold_data = sample_data;
    end
  end

  initial begin
    forever begin
      @(negedge ui_clk);
      if (done) done_cnt++;
    end
  end

  task automatic run_job(input int unsigned base, input int n, input bit lp,
                         input logic [15:0] salt);
    @(negedge ui_clk);
    job_base = base;
    job_n    = n;
    job_salt = salt;
    job_id++;
    done0 = done_cnt;
    got0  = got_cnt;
    base_addr = ADDR_W'(base);
    num_words = 16'(n);
    loop_en   = lp;
    start     = 1'b1;
    @(negedge ui_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_cnt == done0 && n < 20000) begin
      @(negedge ui_clk);
      n++;
    end
    check({name, "_done_seen"}, done_cnt != done0, 1);
  endtask

  task automatic end_job(input string name, input int n_cmds);
    wait_done(name);
    repeat (3) @(negedge ui_clk);
    check({name, "_done_pulses"}, done_cnt - done0, 1);
    check({name, "_busy_low"}, busy, 0);
    check({name, "_cmds"}, job_acc, n_cmds);
    check({name, "_samples"}, got_cnt - got0, 16 * n_cmds);
    check({name, "_sb_empty"}, exp_q.size(), 0);
    check({name, "_err"}, err, 0);
    check({name, "_credit"}, max_out <= int'(FIFO_DEPTH + 1), 1);
  endtask

  initial begin
    int en0;
    ui_clk_sync_rst = 1'b1;
    init_calib_complete = 1'b1;
    start = 1'b0;
    base_addr = '0;
    num_words = '0;
    loop_en = 1'b0;
    repeat (3) @(negedge ui_clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_app_en", app_en, 0);
    check("rst_app_addr", app_addr, 0);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_sample_data", sample_data, 0);
    check("rst_app_cmd", app_cmd, 3'b001);
    ui_clk_sync_rst = 1'b0;

    // Basic one-shot job, samples 0..63.
    run_job(32'h100, 4, 1'b0, 16'h0);
    check("basic_busy", busy, 1);
    end_job("basic", 4);

    // Same job with command stalls and slow read data.
    rdy_mode = 1; dmin = 5; dmax = 20;
    run_job(32'h100, 4, 1'b0, 16'h0);
    end_job("stall", 4);

    // Downstream backpressure fills the credit window.
    rdy_mode = 0; dmin = 1; dmax = 4; sr_mode = 1;
    run_job(32'h1000, 32, 1'b0, 16'(($urandom())));
    repeat (200) @(negedge ui_clk);
    check("bp_cmds_bounded", job_acc <= int'(FIFO_DEPTH + 1), 1);
    check("bp_app_en_low", app_en, 0);
    check("bp_err", err, 0);
    sr_mode = 0;
    end_job("bp", 32);

    // Looped playback stopped after five commands.
    stop_after = 5; rdy_mode = 2; sr_mode = 2;
    run_job(32'h40, 2, 1'b1, 16'(($urandom())));
    end_job("loop", 5);
    stop_after = 0;

    // Empty job.
    rdy_mode = 0; sr_mode = 0;
    en0 = en_cycles;
    run_job(32'h500, 0, 1'b0, 16'h0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    repeat (3) @(negedge ui_clk);
    check("zero_no_en", en_cycles - en0, 0);
    check("zero_done_pulses", done_cnt - done0, 1);

    // Calibration gating.
    init_calib_complete = 1'b0;
    en0 = en_cycles;
    run_job(32'h200, 2, 1'b0, 16'(($urandom())));
    repeat (20) @(negedge ui_clk);
    check("cal_no_en", en_cycles - en0, 0);
    check("cal_busy", busy, 1);
    init_calib_complete = 1'b1;
    end_job("cal", 2);

    // Spurious read data while idle.
    inject_req++;
    repeat (5) @(negedge ui_clk);
    check("inject_err", err, 1);
    check("inject_no_sample", sample_valid, 0);

    // Reset in the middle of a job, then a fresh job.
    rdy_mode = 2; sr_mode = 2;
    run_job(32'h300, 32, 1'b0, 16'(($urandom())));
    repeat (40) @(negedge ui_clk);
    ui_clk_sync_rst = 1'b1;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_err", err, 0);
    check("mrst_app_en", app_en, 0);
    check("mrst_app_addr", app_addr, 0);
    check("mrst_sample_valid", sample_valid, 0);
    check("mrst_sample_data", sample_data, 0);
    repeat (3) @(negedge ui_clk);
    ui_clk_sync_rst = 1'b0;
    run_job(32'h80, 3, 1'b0, 16'(($urandom())));
    end_job("fresh", 3);

    // A few random one-shot jobs.
    for (int j = 0; j < 3; j++) begin
      int n;
      n = $urandom_range(1, 6);
      dmin = 1; dmax = $urandom_range(1, 12);
      run_job(8 * $urandom_range(0, 4095), n, 1'b0, 16'(($urandom())));
      end_job("rand", n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_sample_streamer.md
Name: ddr3_sample_streamer

Overview:
- Read-side streamer that sits downstream of the DDR3 MIG user (app) interface, in the ui_clk domain.
- Issues read commands for a contiguous region of 256-bit words and buffers the returned data in a credit-protected FIFO.
- Unpacks each word into sixteen 16-bit audio samples and presents them on a valid/ready stream to the sound-generation datapath.
- Supports one-shot playback and looped playback of a stored table.

Parameters:
ADDR_W, 29, MIG app_addr width
DATA_W, 256, MIG app data width
SAMPLE_W, 16, output sample width; DATA_W/SAMPLE_W = 16 samples per word
FIFO_DEPTH, 8, read-data FIFO entries (power of 2, >=2)
ADDR_STEP, 8, app_addr increment per 256-bit word

Ports:
ui_clk  in  1  clock
ui_clk_sync_rst  in  1  asynchronous, active-high reset
init_calib_complete  in  1  MIG calibration done
start  in  1  one-cycle pulse; latch base_addr/num_words/loop_en
stop  in  1  one-cycle pulse; cease issuing, drain, finish
base_addr  in  ADDR_W  first word address (multiple of ADDR_STEP)
num_words  in  16  words per pass; 0 = empty job
loop_en  in  1  wrap to base_addr after last word
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at job end
err  out  1  sticky: read data arrived with zero outstanding
app_addr  out  ADDR_W  MIG command address
app_cmd  out  3  constant 3'b001 (read)
app_en  out  1  command valid
app_rdy  in  1  MIG command ready
app_rd_data  in  DATA_W  MIG read data
app_rd_data_valid  in  1  MIG read data strobe (no backpressure)
sample_data  out  SAMPLE_W  current sample
sample_valid  out  1  sample available
sample_ready  in  1  downstream accept

Behaviour:
- Reset (async): state IDLE; busy=0, done=0, err=0, app_en=0, app_addr=0, sample_valid=0, sample_data=0. All counters, FIFO pointers and the unpack index cleared. app_cmd is 3'b001 at all times.
- Command handshake: a command is accepted in any cycle with app_en && app_rdy. While app_en=1 and app_rdy=0, app_addr and app_en are held stable; a pending command is never withdrawn.
- Credit rule: a new command may be presented only if outstanding + fifo_count + (unpack_valid ? 1 : 0) < FIFO_DEPTH + 1. The FIFO therefore never overflows.
- Outstanding counter: +1 on command accept, -1 on app_rd_data_valid; both in one cycle leaves it unchanged. The counter is 0..FIFO_DEPTH+1 wide.
- States:
  - IDLE: start with num_words=0 -> pulse done, stay IDLE, busy stays 0. Otherwise latch parameters, set busy=1, set word_cnt=0, app_addr=base_addr, then go WAIT_CAL if !init_calib_complete, else ISSUE.
  - WAIT_CAL: -> ISSUE when init_calib_complete=1.
  - ISSUE: app_en=1 when credits allow. On accept: app_addr += ADDR_STEP, word_cnt += 1. When the accepted command is the last word (word_cnt == num_words-1):
    - loop_en=1: app_addr <= base_addr, word_cnt <= 0, stay in ISSUE.
    - loop_en=0: go to DRAIN.
  - stop in ISSUE: finish any pending command (app_en held until accepted), then go to DRAIN. stop in WAIT_CAL -> DRAIN. stop in IDLE or DRAIN is ignored.
  - DRAIN: app_en=0. When outstanding=0, FIFO empty and no unpack word: go IDLE, pulse done, busy=0.
- start outside IDLE is ignored.
- Read data path: on app_rd_data_valid the word is written into the FIFO in the same cycle; data order equals command order (MIG in-order).
- app_rd_data_valid with outstanding=0: data dropped, err set (cleared only by reset).
- Unpacker: holds one word plus a 4-bit index.
  - When empty and the FIFO is non-empty, pop the FIFO into the unpack register. The next cycle sample_valid=1.
  - Sample order: index k outputs bits [16k+15:16k], k = 0..15 (LSB first).
  - Each sample_valid && sample_ready advances k. A transfer at k=15 frees the register, and it reloads in the same cycle if the FIFO is non-empty (gapless stream).
  - sample_data is stable while sample_valid=1 and sample_ready=0.
- Latency: command accept to MIG is MIG-dependent. From app_rd_data_valid in cycle N into an empty pipeline, sample_valid=1 in cycle N+2.
- Reset mid-job: everything returns to the reset state immediately; in-flight data is discarded, because the MIG is reset by the same signal.

Decomposition:
- Package ddr3_stream_pkg:
  - CMD_WRITE=3'b000, CMD_READ=3'b001
  - state encoding IDLE/WAIT_CAL/ISSUE/DRAIN
  - ADDR_STEP and the samples-per-word constant
- Sub-module ddr3_rd_fifo: synchronous FIFO, FIFO_DEPTH x DATA_W, with push/pop/count/empty/full. No read-under-empty and no write-over-full by construction.

Test Plan:
- Start with base=0x100, num_words=4, loop_en=0, calib high, app_rdy=1, sample_ready=1, words with sample = 16*w+k -> app_addr 0x100, 0x108, 0x110, 0x118; 64 samples 0..63 in order; one done pulse; busy returns to 0.
- Same job with app_rdy toggling 1/0 every cycle and random read-data delay of 5-20 cycles -> app_addr held while stalled; identical sample sequence; outstanding never exceeds the credit limit.
- sample_ready=0 for 200 cycles with num_words=32 -> at most FIFO_DEPTH+1 commands accepted, app_en drops; no err; releasing sample_ready -> all 512 samples delivered in order.
- loop_en=1, num_words=2, base=0x40; stop after 5 accepted commands -> addresses 0x40, 0x48, 0x40, 0x48, 0x40; 80 samples delivered; then done.
- start with num_words=0 -> done pulse next cycle, app_en never asserted. start while calib low -> no app_en until calib rises.
- Inject app_rd_data_valid while IDLE -> err=1, no sample. Assert reset mid-job -> all outputs at reset values next cycle; a fresh job then runs correctly.
